// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic bus signals for wb_cmd_master.
// Latency: none; signal bundle only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes, Wishbone ACK on the bus side.
interface wb_cmd_master_if;
    // command stream
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    // response stream
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    // status
    logic        busy;
    // Wishbone classic initiator side
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output busy,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  busy,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one single-beat bus cycle, one response out.
// Latency: accept -> rsp_valid is ack wait + 1 cycle; a full transaction takes at least 3 cycles.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready; ACK timeout bounds BUS.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_cmd_master_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last counter value before the bus cycle is abandoned: cyc stays up for TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              rdy_en;     // low during reset, high from the first edge after release
    logic              accept;
    logic              timeout;

    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       adr_q;
    logic [31:0]       dat_q;
    logic              rsp_vld_q;
    logic [31:0]       rsp_dat_q;
    logic              rsp_err_q;

    assign accept  = (state_q == IDLE) && rdy_en && bus.cmd_valid;
    assign timeout = (tmo_cnt == CNT_LAST);

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; an ACK wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)                         state_d = BUS;
            BUS:  if (bus.wbm_ack_i || timeout)       state_d = RESP;
            RESP: if (bus.rsp_ready)                  state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    // Bus-side and response registers; wbm_* fields keep their last values between cycles.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rdy_en    <= 1'b0;
            tmo_cnt   <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.cmd_we;
                        adr_q   <= bus.cmd_adr;
                        dat_q   <= bus.cmd_dat;
                        sel_q   <= bus.cmd_sel;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        tmo_cnt <= '0;
                    end
                end
                BUS: begin
                    if (bus.wbm_ack_i) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        rsp_dat_q <= we_q ? 32'h0 : bus.wbm_dat_i;
                        rsp_err_q <= 1'b0;
                        rsp_vld_q <= 1'b1;
                    end else if (timeout) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        rsp_dat_q <= 32'h0;
                        rsp_err_q <= 1'b1;
                        rsp_vld_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_vld_q <= 1'b0;
                    end
                end
                default: begin
                    cyc_q <= 1'b0;
                    stb_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE) && rdy_en;
    assign bus.busy      = (state_q != IDLE);
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master with TIMEOUT_CYCLES=4: directed scenarios then randomized transactions.
// Latency: n/a.
// Backpressure: bench drives random ACK wait states and rsp_ready stalls.
module tb_wb_cmd_master;
    localparam int T = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    wb_cmd_master_if bus_if ();

    wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction driven and checked against a transaction-level expectation:
    // slave acks after wait_cy wait states (never if wait_cy >= T), consumer stalls bp cycles.
    task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int wait_cy, input logic [31:0] rd,
                           input int bp);
        bit          exp_err;
        int          exp_len;
        logic [31:0] exp_dat;
        int          len;
        exp_err = (wait_cy >= T);
        exp_len = exp_err ? T : wait_cy + 1;
        exp_dat = (exp_err || we) ? 32'h0 : rd;

        check("idle_cmd_ready", bus_if.cmd_ready, 1);
        bus_if.cmd_we    = we;
        bus_if.cmd_adr   = adr;
        bus_if.cmd_dat   = dat;
        bus_if.cmd_sel   = sel;
        bus_if.cmd_valid = 1'b1;
        tick;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_adr   = $urandom;
        bus_if.cmd_dat   = $urandom;
        bus_if.cmd_sel   = 4'($urandom);
        bus_if.cmd_we    = ~we;

        len = 0;
        while (bus_if.wbm_cyc_o === 1'b1 && len < 3 * T + 8) begin
            len++;
            check("bus_stb", bus_if.wbm_stb_o, 1);
            check("bus_we", bus_if.wbm_we_o, we);
            check("bus_adr", bus_if.wbm_adr_o, adr);
            check("bus_dat", bus_if.wbm_dat_o, dat);
            check("bus_sel", bus_if.wbm_sel_o, sel);
            check("bus_cmd_ready", bus_if.cmd_ready, 0);
            check("bus_rsp_valid", bus_if.rsp_valid, 0);
            bus_if.wbm_ack_i = (len == wait_cy + 1);
            bus_if.wbm_dat_i = bus_if.wbm_ack_i ? rd : $urandom;
            tick;
        end
        bus_if.wbm_ack_i = 1'b0;
        check("cyc_len", len, exp_len);
        check("stb_low", bus_if.wbm_stb_o, 0);
        check("rsp_valid", bus_if.rsp_valid, 1);
        check("rsp_dat", bus_if.rsp_dat, exp_dat);
        check("rsp_err", bus_if.rsp_err, exp_err);

        for (int i = 0; i < bp; i++) begin
            bus_if.wbm_ack_i = 1'($urandom_range(0, 1));
            bus_if.wbm_dat_i = $urandom;
            tick;
            check("hold_rsp_valid", bus_if.rsp_valid, 1);
            check("hold_rsp_dat", bus_if.rsp_dat, exp_dat);
            check("hold_rsp_err", bus_if.rsp_err, exp_err);
            check("hold_cmd_ready", bus_if.cmd_ready, 0);
            check("hold_cyc", bus_if.wbm_cyc_o, 0);
        end
        bus_if.wbm_ack_i = 1'b0;
        bus_if.rsp_ready = 1'b1;
        tick;
        bus_if.rsp_ready = 1'b0;
        check("post_rsp_valid", bus_if.rsp_valid, 0);
        check("post_rsp_dat", bus_if.rsp_dat, exp_dat);
        check("post_rsp_err", bus_if.rsp_err, exp_err);
        check("post_cmd_ready", bus_if.cmd_ready, 1);
        check("post_busy", bus_if.busy, 0);
        check("post_adr_kept", bus_if.wbm_adr_o, adr);
        check("post_we_kept", bus_if.wbm_we_o, we);
    endtask

    // Three reads with cmd_valid and rsp_ready held high and a zero-wait slave.
    task automatic back_to_back;
        int          acc_cyc[$];
        logic [31:0] rsp_q[$];
        int          cyc_hi;
        int          idx;
        bit          will_acc;
        cyc_hi = 0;
        idx    = 0;
        bus_if.rsp_ready = 1'b1;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_sel   = 4'hF;
        bus_if.cmd_dat   = 32'h0;
        bus_if.cmd_adr   = 32'h0000_0100;
        bus_if.cmd_valid = 1'b1;
        for (int c = 0; c < 30 && rsp_q.size() < 3; c++) begin
            will_acc = bus_if.cmd_ready && bus_if.cmd_valid;
            bus_if.wbm_ack_i = bus_if.wbm_cyc_o;
            bus_if.wbm_dat_i = bus_if.wbm_adr_o ^ 32'hDEAD_0000;
            if (bus_if.wbm_cyc_o) cyc_hi++;
            if (bus_if.rsp_valid) rsp_q.push_back(bus_if.rsp_dat);
            tick;
            if (will_acc) begin
                acc_cyc.push_back(c);
                idx++;
                if (idx < 3) bus_if.cmd_adr = 32'h0000_0100 + 32'(idx * 4);
                else         bus_if.cmd_valid = 1'b0;
            end
        end
        bus_if.wbm_ack_i = 1'b0;
        bus_if.rsp_ready = 1'b0;
        bus_if.cmd_valid = 1'b0;
        check("b2b_accepts", acc_cyc.size(), 3);
        check("b2b_rsp_count", rsp_q.size(), 3);
        check("b2b_cyc_cycles", cyc_hi, 3);
        if (acc_cyc.size() == 3) begin
            check("b2b_spacing0", acc_cyc[1] - acc_cyc[0], 3);
            check("b2b_spacing1", acc_cyc[2] - acc_cyc[1], 3);
        end
        if (rsp_q.size() == 3) begin
            for (int i = 0; i < 3; i++)
                check("b2b_rsp_order", rsp_q[i], (32'h0000_0100 + 32'(i * 4)) ^ 32'hDEAD_0000);
        end
    endtask

    // Reset pulse in the middle of a bus cycle.
    task automatic reset_mid_bus;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_adr   = 32'h0000_0040;
        bus_if.cmd_sel   = 4'hF;
        bus_if.cmd_valid = 1'b1;
        tick;
        bus_if.cmd_valid = 1'b0;
        tick;
        check("rst_pre_cyc", bus_if.wbm_cyc_o, 1);
        rst = 1'b1;
        #1;
        check("rst_async_cyc", bus_if.wbm_cyc_o, 0);
        check("rst_async_stb", bus_if.wbm_stb_o, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_cmd_ready", bus_if.cmd_ready, 0);
        check("rst_rsp_valid", bus_if.rsp_valid, 0);
        tick;
        rst = 1'b0;
        tick;
        check("rel_cmd_ready", bus_if.cmd_ready, 1);
        check("rel_rsp_valid", bus_if.rsp_valid, 0);
        tick;
        check("rel_rsp_valid2", bus_if.rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_adr   = '0;
        bus_if.cmd_dat   = '0;
        bus_if.cmd_sel   = '0;
        bus_if.rsp_ready = 1'b0;
        bus_if.wbm_ack_i = 1'b0;
        bus_if.wbm_dat_i = '0;
        #1 rst = 1'b1;
        #21;
        check("reset_cyc", bus_if.wbm_cyc_o, 0);
        check("reset_stb", bus_if.wbm_stb_o, 0);
        check("reset_we", bus_if.wbm_we_o, 0);
        check("reset_sel", bus_if.wbm_sel_o, 0);
        check("reset_adr", bus_if.wbm_adr_o, 0);
        check("reset_dat", bus_if.wbm_dat_o, 0);
        check("reset_rsp_valid", bus_if.rsp_valid, 0);
        check("reset_rsp_dat", bus_if.rsp_dat, 0);
        check("reset_rsp_err", bus_if.rsp_err, 0);
        check("reset_busy", bus_if.busy, 0);
        check("reset_cmd_ready", bus_if.cmd_ready, 0);
        tick;
        rst = 1'b0;
        tick;
        check("release_cmd_ready", bus_if.cmd_ready, 1);

        // write, ack on second bus cycle
        run_txn(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 1, 32'hFFFF_FFFF, 0);
        // zero-wait read with 5 cycles of response backpressure
        run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'h1234_5678, 5);
        // dead slave, then a live read
        run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1000, 32'h5555_AAAA, 1);
        run_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 2, 32'hCAFE_F00D, 0);
        // ack coincides with the last allowed cycle
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, T - 1, 32'hBEEF_0001, 0);

        // stray ack while idle
        bus_if.wbm_ack_i = 1'b1;
        bus_if.wbm_dat_i = 32'h7777_7777;
        tick;
        bus_if.wbm_ack_i = 1'b0;
        check("stray_rsp_valid", bus_if.rsp_valid, 0);
        check("stray_busy", bus_if.busy, 0);
        check("stray_cmd_ready", bus_if.cmd_ready, 1);
        check("stray_rsp_dat", bus_if.rsp_dat, 32'hBEEF_0001);
        tick;
        check("stray_rsp_valid2", bus_if.rsp_valid, 0);

        back_to_back();
        tick;

        reset_mid_bus();
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, 0);

        // randomized transactions, including timeouts and ack/timeout coincidences
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
